// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: frame geometry and FSM states shared by the SPI frame slave.
package spi_frame_pkg;
   localparam int FRAME_W = 32;
   localparam int IDX_W = 4;
   localparam int DATA_W = 28;
   localparam int STATUS_IDX = 0;
   typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/spi_frame_slave_if.sv
// spi_frame_slave_if: SPI pins plus receive strobe, transmit sources and status for the frame slave.
interface spi_frame_slave_if #(parameter int N_CH = 16);
   import spi_frame_pkg::*;
   logic spi_clk, spi_cs, spi_mosi, spi_miso;
   logic rx_valid, frame_err;
   logic [IDX_W-1:0] rx_index;
   logic [DATA_W-1:0] rx_data, status;
   logic [N_CH-1:0] tx_valid, tx_ready;
   logic [N_CH*DATA_W-1:0] tx_data;
   modport slave (
      input spi_clk, spi_cs, spi_mosi, tx_valid, tx_data, status,
      output spi_miso, rx_valid, rx_index, rx_data, frame_err, tx_ready
   );
   modport master (
      output spi_clk, spi_cs, spi_mosi, tx_valid, tx_data, status,
      input spi_miso, rx_valid, rx_index, rx_data, frame_err, tx_ready
   );
endinterface

// File: rtl/spi_sync.sv
// spi_sync: N-stage flip-flop synchroniser with a selectable reset value.
module spi_sync #(
   parameter int STAGES = 2,
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] r;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r <= {STAGES{RST_VAL}};
      else r <= STAGES'({r, d});
   assign q = r[STAGES-1];
endmodule

// File: rtl/spi_frame_slave.sv
// spi_frame_slave: mode-0 SPI slave exchanging one 32-bit indexed frame per chip-select window,
// returning the lowest pending channel word or the status word.
module spi_frame_slave
   import spi_frame_pkg::*;
#(
   parameter int N_CH = 16,
   parameter int SYNC_STAGES = 2
) (
   input logic clk,
   input logic rst_n,
   spi_frame_slave_if.slave bus
);
   state_t state, state_nx;
   logic sck_s, cs_s, mosi_s, sck_q, cs_q, armed;
   logic sck_rise, sck_fall, cs_fall, cs_rise, start, stop, good;
   logic [SYNC_STAGES-1:0] live;
   logic [5:0] cnt;
   logic [FRAME_W-1:0] rx_shift, tx_shift, tx_word;
   logic [IDX_W-1:0] grant, grant_nx;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck  (.clk(clk), .rst_n(rst_n), .d(bus.spi_clk),  .q(sck_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs   (.clk(clk), .rst_n(rst_n), .d(bus.spi_cs),   .q(cs_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (.clk(clk), .rst_n(rst_n), .d(bus.spi_mosi), .q(mosi_s));

   // A CS fall only counts once CS has been seen high with the synchroniser flushed after reset.
   assign sck_rise = sck_s & ~sck_q;
   assign sck_fall = ~sck_s & sck_q;
   assign cs_fall  = armed & cs_q & ~cs_s;
   assign cs_rise  = cs_s & ~cs_q;
   assign bus.spi_miso = (state == SHIFT) & tx_shift[FRAME_W-1];

   always_comb begin
      grant_nx = '0;
      for (int k = N_CH - 1; k >= 1; k--)
         if (bus.tx_valid[k]) grant_nx = IDX_W'(k);
      tx_word = grant_nx == '0 ? {IDX_W'(STATUS_IDX), bus.status}
                               : {grant_nx, bus.tx_data[DATA_W*int'(grant_nx) +: DATA_W]};
   end

   always_comb begin
      start    = (state == IDLE) && cs_fall;
      stop     = (state == SHIFT) && cs_rise;
      good     = stop && cnt == 6'd32;
      state_nx = start ? SHIFT : stop ? IDLE : state;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sck_q         <= 1'b0;
         cs_q          <= 1'b1;
         live          <= '0;
         armed         <= 1'b0;
         cnt           <= '0;
         rx_shift      <= '0;
         tx_shift      <= '0;
         grant         <= '0;
         bus.rx_valid  <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.tx_ready  <= '0;
         bus.rx_index  <= '0;
         bus.rx_data   <= '0;
      end else begin
         sck_q <= sck_s;
         cs_q  <= cs_s;
         live  <= SYNC_STAGES'({live, 1'b1});
         armed <= armed | (live[SYNC_STAGES-1] & cs_s);
         if (start) begin
            cnt      <= '0;
            tx_shift <= tx_word;
            grant    <= grant_nx;
         end else if (state == SHIFT) begin
            if (sck_rise) begin
               rx_shift <= {rx_shift[FRAME_W-2:0], mosi_s};
               cnt      <= cnt == 6'd33 ? 6'd33 : cnt + 6'd1;
            end
            if (sck_fall) tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
         end
         bus.rx_valid  <= good;
         bus.frame_err <= stop && !good;
         bus.tx_ready  <= good && grant != '0 ? N_CH'(1) << grant : '0;
         if (good) {bus.rx_index, bus.rx_data} <= rx_shift;
      end
endmodule

// File: tb/tb_spi_frame_slave.sv
// tb_spi_frame_slave: host-side SPI driver with a channel-source model; a monitor checks output pulses
// against scoreboard queues filled when frames are issued.
module tb_spi_frame_slave;
   import spi_frame_pkg::*;
   localparam int N = 16;
   localparam int HALF = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   spi_frame_slave_if #(.N_CH(N)) bus();
   spi_frame_slave #(.N_CH(N), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, exp_err = 0;
   logic [31:0] exp_rx[$];
   int exp_rdy[$];
   logic [N-1:0] src_valid;
   logic [27:0] src_data[N];
   logic [27:0] status_m;
   logic [31:0] last_rx;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply();
      bus.tx_valid = src_valid;
      bus.status = status_m;
      for (int k = 0; k < N; k++) bus.tx_data[28*k +: 28] = src_data[k];
   endtask

   // Reference: lowest pending channel 1..N-1 wins, else status on index 0.
   function automatic logic [31:0] expect_word();
      for (int k = 1; k < N; k++)
         if (src_valid[k]) return {4'(k), src_data[k]};
      return {4'h0, status_m};
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_rx_valid"}, 64'(bus.rx_valid), 0);
      check({tag, "_rx_index"}, 64'(bus.rx_index), 0);
      check({tag, "_rx_data"}, 64'(bus.rx_data), 0);
      check({tag, "_frame_err"}, 64'(bus.frame_err), 0);
      check({tag, "_tx_ready"}, 64'(bus.tx_ready), 0);
      check({tag, "_miso"}, 64'(bus.spi_miso), 0);
   endtask

   task automatic frame(input logic [31:0] w, input int nbits, input int rst_at);
      logic [31:0] got, exp_w;
      int k_win;
      exp_w = expect_word();
      k_win = int'(exp_w[31:28]);
      got = '0;
      bus.spi_cs = 1'b0;
      bus.spi_mosi = w[31];
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            check_zero("midrst");
            @(negedge clk);
            rst_n = 1'b1;
         end
         if (i < 32) got[31-i] = bus.spi_miso;
         bus.spi_clk = 1'b1;
         repeat (HALF) @(negedge clk);
         bus.spi_clk = 1'b0;
         bus.spi_mosi = i < 31 ? w[30-i] : 1'($urandom);
         repeat (HALF) @(negedge clk);
      end
      bus.spi_cs = 1'b1;
      bus.spi_mosi = 1'b0;
      if (rst_at < 0) begin
         if (nbits == 32) begin
            exp_rx.push_back(w);
            last_rx = w;
            if (k_win != 0) exp_rdy.push_back(k_win);
            check("miso_word", 64'(got), 64'(exp_w));
         end else exp_err++;
      end
      repeat (HALF) @(negedge clk);
      if (rst_at < 0 && nbits == 32 && k_win != 0) src_valid[k_win] = 1'b0;
      apply();
   endtask

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (bus.rx_valid) begin
            if (exp_rx.size() == 0) check("rx_unexpected", 64'(bus.rx_valid), 0);
            else check("rx_frame", 64'({bus.rx_index, bus.rx_data}), 64'(exp_rx.pop_front()));
         end
         if (bus.tx_ready != '0) begin
            if (exp_rdy.size() == 0) check("tx_ready_unexpected", 64'(bus.tx_ready), 0);
            else check("tx_ready", 64'(bus.tx_ready), 64'(1) << exp_rdy.pop_front());
         end
         if (bus.frame_err) begin
            check("frame_err_expected", 64'(exp_err > 0), 1);
            if (exp_err > 0) exp_err--;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      bus.spi_clk = 1'b0;
      bus.spi_cs = 1'b1;
      bus.spi_mosi = 1'b0;
      src_valid = '0;
      status_m = '0;
      last_rx = '0;
      for (int k = 0; k < N; k++) src_data[k] = '0;
      apply();
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      status_m = 28'hABCDEF0;
      apply();
      frame(32'h3123_4567, 32, -1);
      src_valid[5] = 1'b1; src_data[5] = 28'h5555555;
      src_valid[2] = 1'b1; src_data[2] = 28'h2222222;
      apply();
      repeat (3) frame($urandom, 32, -1);
      src_valid[7] = 1'b1; src_data[7] = 28'($urandom);
      apply();
      frame($urandom, 16, -1);
      frame($urandom, 32, -1);
      frame($urandom, 33, -1);
      check("hold_rx_index", 64'(bus.rx_index), 64'(last_rx[31:28]));
      check("hold_rx_data", 64'(bus.rx_data), 64'(last_rx[27:0]));
      frame($urandom, 32, 10);
      frame(32'hF000_0001, 32, -1);
      check("fresh_rx_index", 64'(bus.rx_index), 64'hF);
      check("fresh_rx_data", 64'(bus.rx_data), 64'h1);
      for (int f = 0; f < 250; f++) begin
         for (int k = 0; k < N; k++)
            if (!src_valid[k] && $urandom_range(3) == 0) begin
               src_valid[k] = 1'b1;
               src_data[k] = 28'($urandom);
            end
         if ($urandom_range(7) == 0) status_m = 28'($urandom);
         apply();
         nb = 32;
         if ($urandom_range(15) == 0) begin
            nb = $urandom_range(40);
            if (nb == 32) nb = 31;
         end
         frame($urandom, nb, -1);
      end
      repeat (10) @(negedge clk);
      check("rx_left", 64'(exp_rx.size()), 0);
      check("rdy_left", 64'(exp_rdy.size()), 0);
      check("err_left", 64'(exp_err), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
